rv_io_intc: RTL and testbench



---
 rtl/rv_intc_pkg.sv | 11 +
 rtl/rv_intc_gateway.sv | 29 ++
 rtl/rv_io_intc.sv | 132 +++++++++++++
 tb/tb_rv_io_intc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_intc_pkg.sv
// Shared constants for the rv_io interrupt controller: register indices and field widths.
package rv_intc_pkg;
   localparam int PRIO_W = 3;
   localparam int ID_W   = 5;

   localparam logic [8:0] INTC_PENDING   = 9'd0;
   localparam logic [8:0] INTC_ENABLE    = 9'd1;
   localparam logic [8:0] INTC_THRESH    = 9'd2;
   localparam logic [8:0] INTC_CLAIM     = 9'd3;
   localparam logic [8:0] INTC_PRIO_BASE = 9'd4;
endpackage

// File: rtl/rv_intc_gateway.sv
// Per-source gateway: latches a level request once, then blocks it until the
// claim/complete handshake for that source has finished.
module rv_intc_gateway (
   input  logic clk,
   input  logic reset,
   input  logic src,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_flight
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending   <= 1'b0;
         in_flight <= 1'b0;
      end else if (claim) begin
         // Claim wins over a simultaneous capture of the same source
         pending   <= 1'b0;
         in_flight <= 1'b1;
      end else begin
         if (src && !pending && !in_flight)
            pending <= 1'b1;
         if (complete)
            in_flight <= 1'b0;
      end
   end

endmodule

// File: rtl/rv_io_intc.sv
// Memory-mapped interrupt controller: config registers, winner selection,
// claim/complete decode, bus read path and the registered request to the core.
module rv_io_intc
   import rv_intc_pkg::*;
#(
   parameter int RV   = 64,
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            addr_req,
   output logic            addr_ack,
   input  logic            sel,
   input  logic [11:0]     addr,
   input  logic            read,
   input  logic [7:0]      mask,
   input  logic [RV-1:0]   wdata,
   output logic            data_req,
   input  logic            data_ack,
   output logic [RV-1:0]   rdata,
   input  logic [NSRC-1:0] irq_src,
   output logic            irq_out
);

   logic [8:0]                   idx;
   logic                         rd_acc;
   logic                         wr_acc;
   logic                         claim_rd;
   logic                         complete_wr;
   logic [NSRC-1:0]              enable;
   logic [PRIO_W-1:0]            threshold;
   logic [NSRC-1:0][PRIO_W-1:0]  prio;
   logic [NSRC-1:0]              pending;
   logic [NSRC-1:0]              in_flight;
   logic [NSRC-1:0]              eligible;
   logic [NSRC-1:0]              claim_vec;
   logic [NSRC-1:0]              complete_vec;
   logic [ID_W-1:0]              win_id;
   logic [PRIO_W-1:0]            win_prio;
   logic [31:0]                  rd_mux;
   logic [31:0]                  r_data;
   logic                         unused;

   assign idx         = addr[11:3];
   assign addr_ack    = addr_req & sel;
   assign rd_acc      = addr_req & sel & read;
   assign wr_acc      = addr_req & sel & ~read;
   assign claim_rd    = rd_acc & (idx == INTC_CLAIM);
   assign complete_wr = wr_acc & (idx == INTC_CLAIM) & mask[0];
   assign rdata       = {{(RV-32){1'b0}}, r_data};
   assign unused      = ^{mask, wdata, addr[2:0]};

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         assign eligible[gi]     = pending[gi] & enable[gi] & (prio[gi] > threshold);
         assign claim_vec[gi]    = claim_rd & (win_id == ID_W'(gi + 1));
         assign complete_vec[gi] = complete_wr & (wdata[ID_W-1:0] == ID_W'(gi + 1));

         rv_intc_gateway u_gateway (
            .clk       (clk),
            .reset     (reset),
            .src       (irq_src[gi]),
            .claim     (claim_vec[gi]),
            .complete  (complete_vec[gi]),
            .pending   (pending[gi]),
            .in_flight (in_flight[gi])
         );
      end
   endgenerate

   // Strict greater-than while scanning upward keeps the lowest ID on ties
   always_comb begin
      win_id   = '0;
      win_prio = '0;
      for (int s = 0; s < NSRC; s++) begin
         if (eligible[s] && prio[s] > win_prio) begin
            win_prio = prio[s];
            win_id   = ID_W'(s + 1);
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (idx)
         INTC_PENDING: rd_mux = 32'(pending);
         INTC_ENABLE:  rd_mux = 32'(enable);
         INTC_THRESH:  rd_mux = 32'(threshold);
         INTC_CLAIM:   rd_mux = 32'(win_id);
         default: begin
            for (int s = 0; s < NSRC; s++)
               if (idx == INTC_PRIO_BASE + 9'(s))
                  rd_mux = 32'(prio[s]);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable    <= '0;
         threshold <= '0;
         prio      <= '0;
      end else if (wr_acc) begin
         if (idx == INTC_ENABLE)
            for (int b = 0; b < NSRC; b++)
               if (mask[b/8])
                  enable[b] <= wdata[b];
         if (idx == INTC_THRESH && mask[0])
            threshold <= wdata[PRIO_W-1:0];
         for (int s = 0; s < NSRC; s++)
            if (idx == INTC_PRIO_BASE + 9'(s) && mask[0])
               prio[s] <= wdata[PRIO_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data   <= '0;
         data_req <= 1'b0;
         irq_out  <= 1'b0;
      end else begin
         irq_out <= |eligible;
         if (rd_acc) begin
            r_data   <= rd_mux;
            data_req <= 1'b1;
         end else if (data_ack) begin
            data_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rv_io_intc.sv
// Bench for rv_io_intc: directed scenarios then random traffic, all checked
// against a rule-level model of gateways, config and the bus.
module tb_rv_io_intc;
   localparam int RV   = 64;
   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            addr_req;
   logic            addr_ack;
   logic            sel;
   logic [11:0]     addr;
   logic            read;
   logic [7:0]      mask;
   logic [RV-1:0]   wdata;
   logic            data_req;
   logic            data_ack;
   logic [RV-1:0]   rdata;
   logic [NSRC-1:0] irq_src;
   logic            irq_out;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   bit          m_pend [1:NSRC];
   bit          m_infl [1:NSRC];
   bit          m_en   [1:NSRC];
   int          m_pr   [1:NSRC];
   int          m_thr;
   bit          exp_dreq;
   logic [63:0] exp_rdata;

   rv_io_intc #(.RV(RV), .NSRC(NSRC)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr_req (addr_req),
      .addr_ack (addr_ack),
      .sel      (sel),
      .addr     (addr),
      .read     (read),
      .mask     (mask),
      .wdata    (wdata),
      .data_req (data_req),
      .data_ack (data_ack),
      .rdata    (rdata),
      .irq_src  (irq_src),
      .irq_out  (irq_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int id = 1; id <= NSRC; id++) begin
         m_pend[id] = 0;
         m_infl[id] = 0;
         m_en[id]   = 0;
         m_pr[id]   = 0;
      end
      m_thr     = 0;
      exp_dreq  = 0;
      exp_rdata = '0;
   endtask

   // Highest priority level first, then lowest ID within that level
   function automatic int model_winner();
      int res = 0;
      for (int p = 7; p >= 1; p--)
         for (int id = 1; id <= NSRC; id++)
            if (res == 0 && p > m_thr && m_pr[id] == p && m_pend[id] && m_en[id])
               res = id;
      return res;
   endfunction

   function automatic logic [31:0] model_read(input int idx, input int w);
      logic [31:0] v = '0;
      if (idx == 0) begin
         for (int id = 1; id <= NSRC; id++) v[id-1] = m_pend[id];
      end else if (idx == 1) begin
         for (int id = 1; id <= NSRC; id++) v[id-1] = m_en[id];
      end else if (idx == 2) begin
         v = 32'(m_thr);
      end else if (idx == 3) begin
         v = 32'(w);
      end else if (idx >= 4 && idx < 4 + NSRC) begin
         v = 32'(m_pr[idx-3]);
      end
      return v;
   endfunction

   // One clock of bus activity; model is advanced with pre-edge state
   task automatic step(input bit rd, input bit wr, input int idx, input logic [7:0] m,
                       input logic [63:0] wd, input bit ack, input bit s);
      int w;
      int clm;
      int cmp;
      bit acc;
      logic [31:0] rv;
      sel      = s;
      addr_req = rd | wr;
      read     = rd;
      addr     = 12'(idx * 8);
      mask     = m;
      wdata    = wd;
      data_ack = ack;
      acc      = s & (rd | wr);
      #1;
      chk("addr_ack", {63'b0, addr_ack}, {63'b0, acc});
      w   = model_winner();
      rv  = model_read(idx, w);
      clm = (acc && rd && idx == 3) ? w : 0;
      cmp = (acc && wr && idx == 3 && m[0]) ? int'(wd[4:0]) : 0;
      for (int id = 1; id <= NSRC; id++) begin
         if (clm == id) begin
            m_pend[id] = 0;
            m_infl[id] = 1;
         end else begin
            if (irq_src[id-1] && !m_pend[id] && !m_infl[id]) m_pend[id] = 1;
            if (cmp == id) m_infl[id] = 0;
         end
      end
      if (acc && wr) begin
         if (idx == 1)
            for (int b = 0; b < NSRC; b++)
               if (m[b/8]) m_en[b+1] = wd[b];
         if (idx == 2 && m[0]) m_thr = int'(wd[2:0]);
         if (idx >= 4 && idx < 4 + NSRC && m[0]) m_pr[idx-3] = int'(wd[2:0]);
      end
      if (acc && rd) begin
         exp_dreq  = 1;
         exp_rdata = {32'b0, rv};
      end else if (ack) begin
         exp_dreq = 0;
      end
      @(posedge clk);
      #1;
      chk("irq_out", {63'b0, irq_out}, {63'b0, (w != 0)});
      chk("data_req", {63'b0, data_req}, {63'b0, exp_dreq});
      chk("rdata", rdata, exp_rdata);
      if (acc) begin
         n_txn++;
         $display("txn %0d %s idx=%0d wdata=%0h mask=%0h rdata=%0h irq_out=%0b",
                  n_txn, rd ? "rd" : "wr", idx, wd, m, rdata, irq_out);
      end
      addr_req = 1'b0;
      data_ack = 1'b0;
   endtask

   task automatic rd_reg(input int idx);
      step(1, 0, idx, 8'h0f, 64'd0, 0, 1);
   endtask

   task automatic wr_reg(input int idx, input logic [63:0] v);
      step(0, 1, idx, 8'h0f, v, 0, 1);
   endtask

   task automatic idle(input int n, input bit ack);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 64'd0, ack, 1);
   endtask

   initial begin
      reset    = 1'b1;
      addr_req = 1'b0;
      sel      = 1'b0;
      addr     = '0;
      read     = 1'b0;
      mask     = '0;
      wdata    = '0;
      data_ack = 1'b0;
      irq_src  = '0;
      model_reset();
      #12;
      chk("rst_data_req", {63'b0, data_req}, 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_irq_out", {63'b0, irq_out}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset values of the first registers
      for (int i = 0; i <= 4; i++) begin
         rd_reg(i);
         chk("rst_reg_rd", rdata, 64'd0);
         idle(1, 1);
      end

      // Single source: capture, request, claim
      wr_reg(1, 64'h01);
      wr_reg(4, 64'd3);
      wr_reg(2, 64'd2);
      irq_src = 8'h01;
      idle(1, 0);
      irq_src = 8'h00;
      idle(1, 0);
      chk("src1_irq", {63'b0, irq_out}, 64'd1);
      rd_reg(3);
      chk("claim1", rdata, 64'd1);
      idle(1, 1);
      chk("claim1_irq_drop", {63'b0, irq_out}, 64'd0);
      rd_reg(0);
      chk("claim1_pend", rdata, 64'd0);
      idle(1, 1);

      // Priority tie goes to lower ID, then higher priority wins
      wr_reg(1, 64'h13);
      wr_reg(5, 64'd4);
      wr_reg(8, 64'd4);
      irq_src = 8'h12;
      idle(1, 0);
      irq_src = 8'h00;
      idle(1, 0);
      rd_reg(3);
      chk("tie_claim", rdata, 64'd2);
      idle(1, 1);
      wr_reg(8, 64'd6);
      rd_reg(3);
      chk("prio_claim", rdata, 64'd5);
      idle(1, 1);

      // Held source blocked while in flight, re-pends after complete
      irq_src = 8'h01;
      idle(3, 0);
      rd_reg(0);
      chk("held_no_repend", rdata, 64'd0);
      idle(1, 1);
      wr_reg(3, 64'd1);
      idle(1, 0);
      rd_reg(0);
      chk("repend", rdata, 64'd1);
      chk("repend_irq", {63'b0, irq_out}, 64'd1);
      irq_src = 8'h00;
      idle(1, 1);

      // Priority equal to threshold is not eligible
      wr_reg(2, 64'd5);
      wr_reg(4, 64'd5);
      idle(2, 0);
      chk("thresh_irq", {63'b0, irq_out}, 64'd0);
      rd_reg(3);
      chk("thresh_claim", rdata, 64'd0);
      idle(1, 1);
      rd_reg(0);
      chk("thresh_pend", rdata, 64'd1);
      idle(1, 1);

      // Completes that must be ignored, then a real one
      wr_reg(3, 64'd0);
      wr_reg(3, 64'd9);
      wr_reg(3, 64'd1);
      wr_reg(3, 64'd3);
      rd_reg(0);
      chk("bad_complete_pend", rdata, 64'd1);
      idle(1, 1);
      wr_reg(3, 64'd2);
      wr_reg(2, 64'd0);
      rd_reg(3);
      chk("after_complete_claim", rdata, 64'd1);
      idle(1, 1);

      // Reset during an outstanding read
      rd_reg(0);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_data_req", {63'b0, data_req}, 64'd0);
      chk("mid_rst_rdata", rdata, 64'd0);
      chk("mid_rst_irq", {63'b0, irq_out}, 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Random traffic
      for (int t = 0; t < 600; t++) begin
         int op;
         int idx;
         logic [7:0] m;
         logic [63:0] wd;
         if ($urandom_range(0, 3) == 0) irq_src = NSRC'($urandom);
         op = $urandom_range(0, 9);
         m  = 8'($urandom);
         if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
         if (op <= 3) begin
            idx = (op < 2) ? 3 : $urandom_range(0, 13);
            step(1, 0, idx, m, 64'd0, $urandom_range(0, 1), $urandom_range(0, 7) != 0);
         end else if (op <= 6) begin
            idx = $urandom_range(0, 13);
            wd  = {$urandom, $urandom};
            if (idx == 3) wd = 64'($urandom_range(0, 10));
            step(0, 1, idx, m, wd, $urandom_range(0, 1), $urandom_range(0, 7) != 0);
         end else begin
            step(0, 0, 0, 8'h00, 64'd0, $urandom_range(0, 1), 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
